// File: rtl/c17_bist_driver.sv
// c17_bist_driver
//   Built-in self-test driver for the bit-level pipelined c17 core. Drives the
//   exhaustive 5-bit pattern set onto N1/N2/N3/N6/N7 at one pattern per cycle.
//   The N22/N23 responses are aligned to the core's pipeline latency and then
//   compacted into a MISR. At the end of a run the block reports the signature
//   and a pass/fail verdict against a supplied golden value.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             single-cycle run request (ignored while busy)
//   golden            expected final signature, sampled as done rises
//   N22, N23          responses from the c17 core
//   N1,N2,N3,N6,N7    registered pattern bits k[0..4]
//   busy              run or drain in progress
//   done              run complete, held until the next accepted start
//   pass              signature == golden, meaningful while done=1
//   signature         current MISR contents
//
// Optional feature (macro C17_BIST_XCHK_EN)
//   Adds an internal c17 reference model that is checked on every capture.
//   The result appears on fail_any (sticky per run) and on fail_idx (the index
//   of the first mismatching pattern).
module c17_bist_driver #(
    parameter int unsigned          LATENCY  = 3,
    parameter int unsigned          PATTERNS = 32,
    parameter int unsigned          MISR_W   = 16,
    parameter logic [MISR_W-1:0]    POLY     = 16'h1021,
    parameter logic [MISR_W-1:0]    SEED     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MISR_W-1:0] golden,
    input  logic              N22,
    input  logic              N23,
    output logic              N1,
    output logic              N2,
    output logic              N3,
    output logic              N6,
    output logic              N7,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
`ifdef C17_BIST_XCHK_EN
    ,
    output logic              fail_any,
    output logic [4:0]        fail_idx
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // The counter must be able to hold PATTERNS (at most 32) without wrapping.
    localparam logic [5:0] PAT_END = 6'(PATTERNS);

    logic [1:0]         state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [4:0]         pat_q, pat_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [MISR_W-1:0]  sig_q, sig_d, misr_next;
    logic               pass_q, pass_d;
    logic               push, capture, accept;

    assign accept  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign push    = (state_q == ST_RUN);
    assign capture = vld_q[LATENCY-1];

    // Valid pipe: one bit per driven pattern, emerging when its response is due.
    if (LATENCY == 1) begin : g_vld_one
        assign vld_d = push;
    end else begin : g_vld_many
        assign vld_d = {vld_q[LATENCY-2:0], push};
    end

    assign misr_next = {sig_q[MISR_W-2:0], 1'b0}
                     ^ (sig_q[MISR_W-1] ? POLY : '0)
                     ^ {{(MISR_W-2){1'b0}}, N23, N22};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        pass_d  = pass_q;
        sig_d   = capture ? misr_next : sig_q;
        if (accept) begin
            // Pattern 0 goes out on the accepting edge; the counter names the next one.
            state_d = ST_RUN;
            cnt_d   = 6'd1;
            pat_d   = 5'd0;
            sig_d   = SEED;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (cnt_q == PAT_END) begin
                        state_d = ST_DRAIN;
                    end else begin
                        pat_d = cnt_q[4:0];
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                ST_DRAIN: begin
                    // Pipe empties on the edge of the final capture.
                    if (vld_d == '0) begin
                        state_d = ST_DONE;
                        pass_d  = (sig_d == golden);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            vld_q   <= '0;
            sig_q   <= SEED;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            vld_q   <= vld_d;
            sig_q   <= sig_d;
            pass_q  <= pass_d;
        end
    end

    assign {N7, N6, N3, N2, N1} = pat_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign signature = sig_q;

`ifdef C17_BIST_XCHK_EN
    // Pattern delay line aligned with the valid pipe.
    logic [4:0] pdly_q [LATENCY];
    logic [4:0] chk_pat;
    logic [1:0] chk_resp;
    logic       n10, n11, n16, n19;
    logic       mismatch;
    logic       fail_any_q;
    logic [4:0] fail_idx_q;

    always_comb begin
        chk_pat  = pdly_q[LATENCY-1];
        n10      = ~(chk_pat[0] & chk_pat[2]);
        n11      = ~(chk_pat[2] & chk_pat[3]);
        n16      = ~(chk_pat[1] & n11);
        n19      = ~(n11 & chk_pat[4]);
        chk_resp = {~(n16 & n19), ~(n10 & n16)};
        mismatch = (chk_resp != {N23, N22});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) pdly_q[i] <= '0;
            fail_any_q <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            pdly_q[0] <= pat_q;
            for (int unsigned i = 1; i < LATENCY; i++) pdly_q[i] <= pdly_q[i-1];
            if (accept) begin
                fail_any_q <= 1'b0;
                fail_idx_q <= '0;
            end else if (capture && mismatch && !fail_any_q) begin
                fail_any_q <= 1'b1;
                fail_idx_q <= chk_pat;
            end
        end
    end

    assign fail_any = fail_any_q;
    assign fail_idx = fail_idx_q;
`endif

endmodule

// File: tb/tb_c17_bist_driver.sv
module tb_c17_bist_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] golden = '0;
    logic        N22, N23, N1, N2, N3, N6, N7;
    logic        busy, done, pass;
    logic [15:0] signature;

    // Second instance: two patterns, responses tied to N22=1, N23=0.
    logic        start2 = 1'b0;
    logic        s_n1, s_n2, s_n3, s_n6, s_n7, busy2, done2, pass2;
    logic [15:0] sig2;

`ifdef C17_BIST_XCHK_EN
    logic        fail_any, fail_any2;
    logic [4:0]  fail_idx, fail_idx2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0]  patq [$];
    logic [15:0] sigq [$];

    // Pipelined c17 stand-in: three register stages after the logic.
    logic [1:0] p0 = '0, p1 = '0, p2 = '0;
    bit         stuck22 = 1'b0;

    always #5 clk = ~clk;

    c17_bist_driver dut (
        .clk(clk), .rst_n(rst_n), .start(start), .golden(golden),
        .N22(N22), .N23(N23),
        .N1(N1), .N2(N2), .N3(N3), .N6(N6), .N7(N7),
        .busy(busy), .done(done), .pass(pass), .signature(signature)
`ifdef C17_BIST_XCHK_EN
        , .fail_any(fail_any), .fail_idx(fail_idx)
`endif
    );

    c17_bist_driver #(.PATTERNS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .golden(16'h0003),
        .N22(1'b1), .N23(1'b0),
        .N1(s_n1), .N2(s_n2), .N3(s_n3), .N6(s_n6), .N7(s_n7),
        .busy(busy2), .done(done2), .pass(pass2), .signature(sig2)
`ifdef C17_BIST_XCHK_EN
        , .fail_any(fail_any2), .fail_idx(fail_idx2)
`endif
    );

    function automatic logic [1:0] c17(input logic [4:0] k);
        logic n10, n11, n16, n19;
        n10 = ~(k[0] & k[2]);
        n11 = ~(k[2] & k[3]);
        n16 = ~(k[1] & n11);
        n19 = ~(n11 & k[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    function automatic logic [15:0] model_sig(input bit stuck);
        logic [15:0] s;
        logic [1:0]  r;
        s = 16'h0000;
        for (int k = 0; k < 32; k++) begin
            r = c17(5'(k));
            if (stuck) r[0] = 1'b0;
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'd0, r};
        end
        return s;
    endfunction

    always @(posedge clk) begin
        p0 <= c17({N7, N6, N3, N2, N1});
        p1 <= p0;
        p2 <= p1;
    end
    assign N22 = stuck22 ? 1'b0 : p2[0];
    assign N23 = p2[1];

    // Called 1 time unit after a rising edge; returns 1 unit after E(PATTERNS+LATENCY).
    task automatic run_main(input logic [15:0] g, input bit stuck, input bit poke,
                            output logic [15:0] s_out);
        logic [15:0] es;
        logic [4:0]  ep, obs;
        es      = model_sig(stuck);
        golden  = g;
        stuck22 = stuck;
        for (int k = 0; k < 32; k++) patq.push_back(5'(k));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 35; cyc++) begin
            obs = {N7, N6, N3, N2, N1};
            ep  = (patq.size() != 0) ? patq.pop_front() : 5'd31;
            n_checks++;
            if (obs !== ep) begin
                n_fail++;
                $display("FAIL pattern cyc=%0d got=%0d exp=%0d", cyc, obs, ep);
            end
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_done_run cyc=%0d got busy=%b done=%b exp busy=1 done=0",
                         cyc, busy, done);
            end
            if (cyc == 0) begin
                n_checks++;
                if (pass !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pass_clear got=%b exp=0", pass);
                end
            end
            start = poke && (cyc == 5 || cyc == 33);
            @(posedge clk); #1;
            start = 1'b0;
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_edge got done=%b busy=%b exp done=1 busy=0", done, busy);
        end
        n_checks++;
        if (signature !== es) begin
            n_fail++;
            $display("FAIL signature got=%h exp=%h", signature, es);
        end
        n_checks++;
        if (pass !== (es == g)) begin
            n_fail++;
            $display("FAIL pass got=%b exp=%b", pass, (es == g));
        end
`ifdef C17_BIST_XCHK_EN
        n_checks++;
        if (fail_any !== stuck) begin
            n_fail++;
            $display("FAIL fail_any got=%b exp=%b", fail_any, stuck);
        end
        if (stuck) begin
            n_checks++;
            if (fail_idx !== 5'd2) begin
                n_fail++;
                $display("FAIL fail_idx got=%0d exp=2", fail_idx);
            end
        end
`endif
        s_out = signature;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({N7, N6, N3, N2, N1, busy, done, pass} !== 8'd0 || signature !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_main got pat=%b busy=%b done=%b pass=%b sig=%h exp all 0",
                     {N7, N6, N3, N2, N1}, busy, done, pass, signature);
        end
        n_checks++;
        if ({busy2, done2, pass2} !== 3'd0 || sig2 !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_stub got busy=%b done=%b pass=%b sig=%h exp all 0",
                     busy2, done2, pass2, sig2);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [15:0] s_ref, s_tmp;

    task automatic test_golden;
        run_main(16'h0000, 1'b0, 1'b0, s_ref);
        run_main(s_ref, 1'b0, 1'b0, s_tmp);
        n_checks++;
        if (s_tmp !== s_ref) begin
            n_fail++;
            $display("FAIL repeat_signature got=%h exp=%h", s_tmp, s_ref);
        end
    endtask

    task automatic test_stuck;
        run_main(s_ref, 1'b1, 1'b0, s_tmp);
        stuck22 = 1'b0;
    endtask

    // Starts from DONE and pokes start during RUN and DRAIN.
    task automatic test_back_to_back;
        run_main(s_ref, 1'b0, 1'b1, s_tmp);
    endtask

    task automatic test_stub;
        logic [15:0] e;
        sigq.push_back(16'h0000); sigq.push_back(16'h0000); sigq.push_back(16'h0000);
        sigq.push_back(16'h0000); sigq.push_back(16'h0001); sigq.push_back(16'h0003);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int j = 0; j < 6; j++) begin
            e = sigq.pop_front();
            n_checks++;
            if (sig2 !== e) begin
                n_fail++;
                $display("FAIL stub_sig after E%0d got=%h exp=%h", j, sig2, e);
            end
            n_checks++;
            if (done2 !== (j == 5) || busy2 !== (j < 5)) begin
                n_fail++;
                $display("FAIL stub_timing after E%0d got done=%b busy=%b exp done=%b busy=%b",
                         j, done2, busy2, (j == 5), (j < 5));
            end
            if (j < 5) begin
                @(posedge clk); #1;
            end
        end
        n_checks++;
        if (pass2 !== 1'b1) begin
            n_fail++;
            $display("FAIL stub_pass got=%b exp=1", pass2);
        end
    endtask

    task automatic test_reset_midrun;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({N7, N6, N3, N2, N1, busy, done, pass} !== 8'd0 || signature !== 16'h0000) begin
            n_fail++;
            $display("FAIL midrun_reset got pat=%b busy=%b done=%b sig=%h exp all 0",
                     {N7, N6, N3, N2, N1}, busy, done, signature);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({N7, N6, N3, N2, N1, busy, done} !== 7'd0 || signature !== 16'h0000) begin
                n_fail++;
                $display("FAIL idle_after_reset cyc=%0d got pat=%b busy=%b done=%b sig=%h",
                         c, {N7, N6, N3, N2, N1}, busy, done, signature);
            end
        end
    endtask

    initial begin
        test_reset;
        test_golden;
        test_stuck;
        test_back_to_back;
        test_stub;
        test_reset_midrun;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/c17_bist_driver.md
# c17_bist_driver

Built-in self-test driver for the bit-level pipelined c17 benchmark. It generates the exhaustive 5-bit pattern set on N1/N2/N3/N6/N7, one pattern per cycle. It aligns the DUT's N22/N23 responses to the known pipeline latency and compacts them into a multiple-input signature register (MISR). At the end of a run it reports the signature and a pass/fail verdict against a supplied golden value. It sits at the stimulus/response end of the pipelined c17 core, driving its inputs and reading its outputs.

## Interface
- LATENCY, 3: cycles from a pattern appearing on N* to its response being sampled on N22/N23 (1..15).
- PATTERNS, 32: number of patterns per run (1..32); pattern k = k[4:0].
- MISR_W, 16: signature width (≥4).
- POLY, 16'h1021: MISR feedback polynomial (low MISR_W bits used).
- SEED, 0: signature value at run start.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a run.
- golden  in  MISR_W  expected final signature; sampled when done rises.
- N22, N23  in  1 each  DUT responses.
- N1, N2, N3, N6, N7  out  1 each  registered pattern bits k[0], k[1], k[2], k[3], k[4].
- busy  out  1  high in RUN or DRAIN.
- done  out  1  run complete; held until the next accepted start or reset.
- pass  out  1  (signature == golden); meaningful only while done=1.
- signature  out  MISR_W  current MISR contents.

## Operation
- The FSM has four states: IDLE, RUN, DRAIN, DONE.
- Reset (async, any state) sends the FSM to IDLE and forces:
  - N*=0, busy=0, done=0, pass=0;
  - signature=SEED;
  - pattern counter=0;
  - valid pipe cleared.
- IDLE/DONE + start=1: clear done and pass, load signature=SEED and counter=0, go to RUN.
- RUN drives pattern k = counter on N* each cycle and pushes 1 into a LATENCY-deep valid pipe.
  - After pattern PATTERNS-1 is driven, go to DRAIN; N* hold the last pattern.
- DRAIN pushes 0 into the valid pipe. When the pipe is empty after the final capture, go to DONE.
- Capture: when the valid pipe output is 1, the MISR updates as sig ← (sig<<1) ^ (sig[MISR_W-1] ? POLY : 0) ^ {0…, N23, N22}.
- In DONE, pass is registered as (sig == golden) on the same edge done rises.
- start while busy is ignored; no queuing.
- The pattern counter is wide enough to hold PATTERNS without wrap.
- At PATTERNS=1, RUN lasts exactly one cycle.

## Timing
- start is sampled at edge E0; pattern k is driven during cycle k+1 (after E0).
- The response to the pattern driven in cycle t is sampled at the end of cycle t+LATENCY.
- The last capture happens at edge E(PATTERNS+LATENCY). done, pass and the final signature become visible after that same edge.
- busy rises after E0 and falls when done rises.
- Total run time is PATTERNS+LATENCY cycles from the accepted start to done.
- Reset asserted mid-run aborts the run with no partial-signature retention. After release, the block waits in IDLE for start.

## Configuration
- C17_BIST_XCHK_EN defined:
  - adds an internal combinational c17 model, evaluated on the pattern delayed LATENCY cycles and compared with N22/N23 on every capture;
  - adds outputs fail_any (1 bit, sticky per run) and fail_idx (5 bits, index of the first mismatching pattern);
  - both outputs reset to 0 and clear on an accepted start.
- Undefined: those ports and logic are absent; the verdict is signature-only.

## Test plan
- Reset mid-run: assert rst_n=0 during RUN.
  - N*=0, busy=0, done=0, signature=SEED, all asynchronously.
  - After release, no activity until start.
- Constant stub: tie N22=1, N23=0; PATTERNS=2, SEED=0, LATENCY=3.
  - signature steps 0x0000 → 0x0001 → 0x0003.
  - done rises at E5, busy falls at E5.
- Real pipelined c17, defaults: run 1 with golden=0 records signature S.
  - Run 2 with golden=S gives pass=1 and an identical signature S.
  - N* sequence during run 2 is 0..31.
- N22 stuck at 0, golden=S: pass=0.
  - With C17_BIST_XCHK_EN: fail_any=1 and fail_idx=2 (first pattern where true N22=1).
- Handshake:
  - start pulsed during RUN and during DRAIN leaves the counter, timing and signature unchanged.
  - start in DONE clears done and pass on the next edge and restarts with pattern 0.
